writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the RISC-V core: the write side of the register file that the decode/register-read stage reads. It accepts one retiring instruction per cycle from execute, selects the write-back source, aligns and extends load data, and drives the regfile write port (`we`/`wa`/`wd`). It waits on a variable-latency data-memory response for loads and holds off the upstream pipeline while it waits.

## Interface
- `DWIDTH`, 32: datapath width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  execute presents a retiring instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `stall`  out  1  equal to `!in_ready`; goes to the decode `stall` input.
- `reg_we`  in  1  the instruction writes rd.
- `rd`  in  5  destination register.
- `funct3`  in  3  load width/sign; used only when `wb_sel`=MEM.
- `wb_sel`  in  2  source: 0 ALU, 1 PC+4, 2 MEM, 3 CSR.
- `alu_result`  in  32  ALU output; bits [1:0] are the load byte offset.
- `pc`  in  32  PC of the instruction.
- `csr_rdata`  in  32  CSR read value.
- `mem_resp_valid`  in  1  load data valid (one-cycle pulse).
- `mem_resp_data`  in  32  word-aligned load data.
- `we`  out  1  regfile write enable.
- `wa`  out  5  regfile write address.
- `wd`  out  32  regfile write data.
- `resp_orphan`  out  1  sticky flag: a memory response arrived while no load was pending.

## Operation
- FSM has two states, IDLE and WAIT_MEM. Reset state is IDLE.
- `in_ready` is 1 in IDLE and 0 in WAIT_MEM. Acceptance is `in_valid && in_ready`.
- Accept in IDLE with `wb_sel`≠MEM:
  - Next cycle: `we` = `reg_we && rd!=0`, `wa` = `rd`.
  - `wd` = `alu_result`, `pc+4` (mod 2^32), or `csr_rdata`, according to `wb_sel`.
  - FSM stays in IDLE.
- Accept in IDLE with `wb_sel`=MEM:
  - Capture `rd`, `reg_we`, `funct3` and `alu_result[1:0]`.
  - Go to WAIT_MEM. `we`=0 next cycle.
- WAIT_MEM with `mem_resp_valid`=1:
  - Extract load data per the rules below.
  - Next cycle: `we` = captured `reg_we && rd!=0`, with captured `wa` and extracted `wd`.
  - Return to IDLE. `in_ready` is 1 in that same next cycle.
- WAIT_MEM with `mem_resp_valid`=0: hold state, `we`=0.
- `mem_resp_valid` in IDLE: the data is discarded and `resp_orphan` is set. Only `rst` clears it.
- Load extraction, with `off` = captured offset:
  - LB (000): sign-extend `data[8*off+:8]`.
  - LBU (100): zero-extend `data[8*off+:8]`.
  - LH (001): sign-extend `data[16*off[1]+:16]`; `off[0]` is ignored. Misaligned accesses are not supported.
  - LHU (101): zero-extend `data[16*off[1]+:16]`; `off[0]` is ignored.
  - LW (010) and all other encodings: the full word.
- `we` is a single-cycle pulse per instruction. `wa`/`wd` hold their last values when `we`=0.
- rd = x0 never produces `we`=1.

## Timing
- Reset values: `we`=0, `wa`=0, `wd`=0, `resp_orphan`=0, state IDLE, `in_ready`=1.
- `rst` asserted in WAIT_MEM:
  - The pending load is dropped and no write occurs.
  - A response in the reset cycle is ignored and does not set `resp_orphan`.
- `we`/`wa`/`wd` are registered outputs. The regfile commits on the edge after `we` rises.
- Non-load latency: 1 cycle from acceptance to `we`. Throughput is 1 instruction per cycle.
- Load latency: the cycle after `mem_resp_valid`. Minimum is 2 cycles from acceptance (response at T+1, `we` at T+2).
- A new instruction can be accepted in the same cycle that the load's `we` is high. Its own write appears one cycle later.
- `in_valid` while `in_ready`=0: the instruction is not consumed. Upstream holds it; this is enforced via `stall`.

## Structure
- Shared package holds:
  - `wb_sel` encodings (WB_ALU, WB_PC4, WB_MEM, WB_CSR).
  - The FSM state typedef.
  - Load `funct3` constants, reused from the existing `FNC_*` defines.
- One sub-module, `load_extract`: combinational; inputs `funct3`, `off`, `data`; output 32-bit result.

## Test plan
- ALU op accepted, rd=5, `alu_result`=0x1234 → next cycle `we`=1, `wa`=5, `wd`=0x1234. `in_ready` stays 1.
- LB, `off`=3, response 0x80FF_0000 at T+3 → `in_ready`=0 for T+1..T+3. At T+4: `we`=1, `wd`=0xFFFF_FF80.
- LHU, `off`=2, data 0xBEEF_1234 → `wd`=0x0000_BEEF. LH with `off`=1, data 0x8000_7FFF → `wd`=0x0000_7FFF.
- JAL with `pc`=0xFFFF_FFFC, rd=1 → `wd`=0x0000_0000. Any op with rd=0 → `we` stays 0.
- `rst` in WAIT_MEM, then `mem_resp_valid` after reset → no `we`, `resp_orphan`=1, `in_ready`=1.
- Back-to-back: ALU, ALU, LW (1-cycle response), ALU → `we` in four distinct cycles, in order, with correct `wa`/`wd` each time.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg
//   Shared definitions for the write-back stage: write-back source
//   encodings, load funct3 codes, the FSM state type and the record
//   captured for a load while its memory response is outstanding.
package writeback_stage_pkg;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_PC4 = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_CSR = 2'd3;

  // Load width / sign encodings (funct3 of the LOAD opcode)
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } wb_state_e;

  // Everything needed to finish a load once its data comes back
  typedef struct packed {
    logic       reg_we;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] off;
  } pend_load_t;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// load_extract
//   Combinational load data alignment and extension.
//   Ports:
//     funct3  in  3   load width/sign
//     off     in  2   byte offset within the word
//     data    in  32  word-aligned memory data
//     result  out 32  aligned, sign/zero-extended value
//   Halfword loads use only off[1]; misaligned halves are not supported.
module load_extract
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (off)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    half_sel = off[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    case (funct3)
      FNC_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: result = {24'd0, byte_sel};
      FNC_LH:  result = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: result = {16'd0, half_sel};
      default: result = data;  // LW and unused encodings pass the word
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage: picks the write-back source, finishes loads
//   when the data memory responds, and drives the register file write
//   port. While a load is outstanding the stage stops accepting work and
//   raises stall toward decode.
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     in_valid / in_ready   handshake with execute; stall = !in_ready
//     reg_we, rd, funct3,
//     wb_sel, alu_result,
//     pc, csr_rdata         retiring instruction fields
//     mem_resp_valid/data   load response (single-cycle pulse)
//     we, wa, wd            registered regfile write port
//     resp_orphan           sticky: response seen with no load pending
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              stall,
  input  logic              reg_we,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [1:0]        wb_sel,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic [DWIDTH-1:0] pc,
  input  logic [DWIDTH-1:0] csr_rdata,
  input  logic              mem_resp_valid,
  input  logic [DWIDTH-1:0] mem_resp_data,
  output logic              we,
  output logic [4:0]        wa,
  output logic [DWIDTH-1:0] wd,
  output logic              resp_orphan
);

  wb_state_e         state, state_nxt;
  pend_load_t        pend, pend_nxt;
  logic              we_nxt;
  logic [4:0]        wa_nxt;
  logic [DWIDTH-1:0] wd_nxt;
  logic              orphan_set;
  logic              accept;
  logic [DWIDTH-1:0] src_data;
  logic [DWIDTH-1:0] load_data;

  load_extract u_load_extract (
    .funct3 (pend.funct3),
    .off    (pend.off),
    .data   (mem_resp_data),
    .result (load_data)
  );

  assign in_ready = (state == S_IDLE);
  assign stall    = ~in_ready;
  assign accept   = in_valid & in_ready;

  // Non-load source mux; WB_MEM never reaches here directly
  always_comb begin
    src_data = alu_result;
    case (wb_sel)
      WB_ALU:  src_data = alu_result;
      WB_PC4:  src_data = pc + DWIDTH'(4);
      WB_CSR:  src_data = csr_rdata;
      default: src_data = alu_result;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    we_nxt     = 1'b0;
    wa_nxt     = wa;
    wd_nxt     = wd;
    orphan_set = 1'b0;
    case (state)
      S_IDLE: begin
        orphan_set = mem_resp_valid;
        if (accept) begin
          if (wb_sel == WB_MEM) begin
            pend_nxt.reg_we = reg_we;
            pend_nxt.rd     = rd;
            pend_nxt.funct3 = funct3;
            pend_nxt.off    = alu_result[1:0];
            state_nxt       = S_WAIT_MEM;
          end else if (reg_we && rd != 5'd0) begin
            we_nxt = 1'b1;
            wa_nxt = rd;
            wd_nxt = src_data;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_resp_valid) begin
          state_nxt = S_IDLE;
          if (pend.reg_we && pend.rd != 5'd0) begin
            we_nxt = 1'b1;
            wa_nxt = pend.rd;
            wd_nxt = load_data;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wa/wd only move with a write so they hold their last value otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pend        <= '0;
      we          <= 1'b0;
      wa          <= 5'd0;
      wd          <= '0;
      resp_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      we    <= we_nxt;
      wa    <= wa_nxt;
      wd    <= wd_nxt;
      if (orphan_set) resp_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        reg_we;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        resp_orphan;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .reg_we(reg_we), .rd(rd), .funct3(funct3),
    .wb_sel(wb_sel), .alu_result(alu_result), .pc(pc),
    .csr_rdata(csr_rdata), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .we(we), .wa(wa), .wd(wd),
    .resp_orphan(resp_orphan)
  );

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rwe;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] csr;
    logic [31:0] mdata;
    int          delay;   // cycles from acceptance to response (loads)
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge; inputs change there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; reg_we = 0; rd = 0; funct3 = 0; wb_sel = 0;
    alu_result = 0; pc = 0; csr_rdata = 0; mem_resp_valid = 0; mem_resp_data = 0;
  endtask

  // Reference load extraction from shifts and masks
  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [1:0] off, logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // Reference model state
  logic        m_pend, m_prwe, m_orph, m_we;
  logic [4:0]  m_prd, m_wa;
  logic [2:0]  m_pf3;
  logic [1:0]  m_poff;
  logic [31:0] m_wd;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    chk("rst_we", we, 0); chk("rst_wa", wa, 0); chk("rst_wd", wd, 0);
    chk("rst_orphan", resp_orphan, 0); chk("rst_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    rst = 0;
    tick();
    chk("post_rst_we", we, 0);

    // name sel f3 rd rwe alu pc csr mdata delay exp_we exp_wd
    tbl.push_back('{"alu_rd5",   2'd0, 3'b000, 5'd5,  1, 32'h1234,      0, 0, 0, 0, 1, 32'h0000_1234});
    tbl.push_back('{"lb_off3",   2'd2, 3'b000, 5'd7,  1, 32'h1003,      0, 0, 32'h80FF_0000, 3, 1, 32'hFFFF_FF80});
    tbl.push_back('{"lhu_off2",  2'd2, 3'b101, 5'd8,  1, 32'h2002,      0, 0, 32'hBEEF_1234, 1, 1, 32'h0000_BEEF});
    tbl.push_back('{"lh_off1",   2'd2, 3'b001, 5'd9,  1, 32'h2001,      0, 0, 32'h8000_7FFF, 2, 1, 32'h0000_7FFF});
    tbl.push_back('{"jal_wrap",  2'd1, 3'b000, 5'd1,  1, 0, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h0000_0000});
    tbl.push_back('{"csr_rd",    2'd3, 3'b000, 5'd9,  1, 0, 0, 32'hCAFE_F00D, 0, 0, 1, 32'hCAFE_F00D});
    tbl.push_back('{"alu_x0",    2'd0, 3'b000, 5'd0,  1, 32'h5555,      0, 0, 0, 0, 0, 0});
    tbl.push_back('{"lbu_off1",  2'd2, 3'b100, 5'd10, 1, 32'h3001,      0, 0, 32'h1234_9876, 1, 1, 32'h0000_0098});
    tbl.push_back('{"lw",        2'd2, 3'b010, 5'd11, 1, 32'h4000,      0, 0, 32'hDEAD_BEEF, 4, 1, 32'hDEAD_BEEF});
    tbl.push_back('{"alu_nowe",  2'd0, 3'b000, 5'd3,  0, 32'h7777,      0, 0, 0, 0, 0, 0});
    tbl.push_back('{"lh_off3",   2'd2, 3'b001, 5'd12, 1, 32'h5003,      0, 0, 32'h8001_0000, 1, 1, 32'hFFFF_8001});
    tbl.push_back('{"ld_f3_111", 2'd2, 3'b111, 5'd13, 1, 32'h6002,      0, 0, 32'h0BAD_CAFE, 2, 1, 32'h0BAD_CAFE});
    tbl.push_back('{"ld_x0",     2'd2, 3'b000, 5'd0,  1, 32'h7000,      0, 0, 32'h0000_00FF, 1, 0, 0});

    foreach (tbl[i]) begin
      chk({tbl[i].name, "_ready_pre"}, in_ready, 1);
      in_valid = 1; wb_sel = tbl[i].sel; funct3 = tbl[i].f3; rd = tbl[i].rd;
      reg_we = tbl[i].rwe; alu_result = tbl[i].alu; pc = tbl[i].pc; csr_rdata = tbl[i].csr;
      tick();
      in_valid = 0;
      if (tbl[i].sel == 2'd2) begin
        for (int k = 1; k <= tbl[i].delay; k++) begin
          chk({tbl[i].name, "_wait_ready"}, in_ready, 0);
          chk({tbl[i].name, "_wait_we"}, we, 0);
          if (k == tbl[i].delay) begin
            mem_resp_valid = 1; mem_resp_data = tbl[i].mdata;
          end
          tick();
        end
        mem_resp_valid = 0;
      end
      chk({tbl[i].name, "_we"}, we, tbl[i].exp_we);
      if (tbl[i].exp_we) begin
        chk({tbl[i].name, "_wa"}, wa, tbl[i].rd);
        chk({tbl[i].name, "_wd"}, wd, tbl[i].exp_wd);
      end
      chk({tbl[i].name, "_ready"}, in_ready, 1);
      tick();
      chk({tbl[i].name, "_we_pulse"}, we, 0);
    end
    chk("tbl_orphan", resp_orphan, 0);

    // Reset while a load is pending, with a response in the reset cycle
    in_valid = 1; wb_sel = 2'd2; funct3 = 3'b010; rd = 5'd4; reg_we = 1; alu_result = 0;
    tick();
    in_valid = 0;
    chk("rstw_ready_wait", in_ready, 0);
    rst = 1; mem_resp_valid = 1; mem_resp_data = 32'h1111_1111;
    tick();
    rst = 0; mem_resp_valid = 0;
    chk("rstw_we", we, 0); chk("rstw_orphan0", resp_orphan, 0); chk("rstw_ready", in_ready, 1);
    mem_resp_valid = 1;
    tick();
    mem_resp_valid = 0;
    chk("rstw_late_we", we, 0); chk("rstw_orphan1", resp_orphan, 1); chk("rstw_ready2", in_ready, 1);
    tick();
    chk("orphan_sticky", resp_orphan, 1);
    rst = 1; tick(); rst = 0;
    chk("orphan_clr", resp_orphan, 0);

    // Back-to-back: ALU, ALU, LW (1-cycle response), ALU
    in_valid = 1; wb_sel = 2'd0; reg_we = 1; rd = 5'd20; alu_result = 32'hA;
    tick();
    rd = 5'd21; alu_result = 32'hB;
    chk("b2b_we1", we, 1); chk("b2b_wa1", wa, 20); chk("b2b_wd1", wd, 32'hA);
    tick();
    wb_sel = 2'd2; funct3 = 3'b010; rd = 5'd22; alu_result = 32'h100;
    chk("b2b_we2", we, 1); chk("b2b_wa2", wa, 21); chk("b2b_wd2", wd, 32'hB);
    tick();
    wb_sel = 2'd0; rd = 5'd23; alu_result = 32'hD;
    mem_resp_valid = 1; mem_resp_data = 32'h1200_0034;
    chk("b2b_gap_we", we, 0); chk("b2b_gap_ready", in_ready, 0); chk("b2b_stall", stall, 1);
    tick();
    mem_resp_valid = 0;
    chk("b2b_we3", we, 1); chk("b2b_wa3", wa, 22); chk("b2b_wd3", wd, 32'h1200_0034);
    chk("b2b_ready3", in_ready, 1);
    tick();
    in_valid = 0;
    chk("b2b_we4", we, 1); chk("b2b_wa4", wa, 23); chk("b2b_wd4", wd, 32'hD);
    tick();
    chk("b2b_end_we", we, 0);

    // Randomized traffic against the reference model
    rst = 1; idle_inputs(); tick(); rst = 0;
    m_pend = 0; m_prwe = 0; m_orph = 0; m_we = 0; m_prd = 0; m_wa = 0;
    m_pf3 = 0; m_poff = 0; m_wd = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        nwe;
      rst            = ($urandom_range(0, 199) == 0);
      in_valid       = $urandom_range(0, 3) != 0;
      wb_sel         = 2'($urandom_range(0, 3));
      funct3         = 3'($urandom_range(0, 7));
      rd             = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      reg_we         = $urandom_range(0, 7) != 0;
      alu_result     = $urandom;
      pc             = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
      csr_rdata      = $urandom;
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data  = $urandom;
      chk("rnd_ready", in_ready, !m_pend);
      chk("rnd_stall", stall, m_pend);
      // next expected state
      nwe = 0;
      if (rst) begin
        m_pend = 0; m_orph = 0; m_wa = 0; m_wd = 0;
      end else if (!m_pend) begin
        if (mem_resp_valid) m_orph = 1;
        if (in_valid) begin
          if (wb_sel == 2'd2) begin
            m_pend = 1; m_prwe = reg_we; m_prd = rd; m_pf3 = funct3; m_poff = alu_result[1:0];
          end else if (reg_we && rd != 0) begin
            nwe = 1; m_wa = rd;
            m_wd = (wb_sel == 2'd1) ? pc + 32'd4 : (wb_sel == 2'd3) ? csr_rdata : alu_result;
          end
        end
      end else if (mem_resp_valid) begin
        m_pend = 0;
        if (m_prwe && m_prd != 0) begin
          nwe = 1; m_wa = m_prd; m_wd = ref_load(m_pf3, m_poff, mem_resp_data);
        end
      end
      m_we = nwe;
      tick();
      chk("rnd_we", we, m_we);
      chk("rnd_wa", wa, m_wa);
      chk("rnd_wd", wd, m_wd);
      chk("rnd_orphan", resp_orphan, m_orph);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
